// File: rtl/palette_write_ctrl.sv
// palette_write_ctrl: queues host palette writes and commits them during vertical blanking,
// and runs a full-palette zeroing sweep on request.
`default_nettype none

module palette_write_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          host_valid,
  output logic                          host_ready,
  input  logic [ADDR_W-1:0]             host_addr,
  input  logic [DATA_W-1:0]             host_data,
  input  logic                          clear_req,
  output logic                          clear_busy,
  input  logic                          vblank,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pend_q, pend_d;
  logic [ADDR_W:0]   sweep_q, sweep_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic enter_clear;

  assign host_ready = (count_q != FULL_CNT);
  assign push       = host_valid && host_ready;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    sweep_d     = sweep_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    busy_d      = busy_q;
    pop         = 1'b0;
    enter_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          enter_clear = 1'b1;
        end else if (vblank && (count_q != '0)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pend_q) begin
          enter_clear = 1'b1;
        end else if (vblank && (count_q != '0)) begin
          pop = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // Top bit of the sweep counter marks that address 2**ADDR_W-1 was already written.
        if (sweep_q[ADDR_W]) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          sweep_d = '0;
        end else begin
          we_d    = 1'b1;
          addr_d  = sweep_q[ADDR_W-1:0];
          wdata_d = '0;
          sweep_d = sweep_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Entering the sweep issues the address-0 write on the same edge.
    if (enter_clear) begin
      state_d = ST_CLEAR;
      busy_d  = 1'b1;
      we_d    = 1'b1;
      addr_d  = '0;
      wdata_d = '0;
      sweep_d = (ADDR_W+1)'(1);
    end

    if (pop) begin
      we_d     = 1'b1;
      addr_d   = fifo_addr_q[rd_ptr_q];
      wdata_d  = fifo_data_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + 1'b1) : wr_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (enter_clear) begin
      pend_d = 1'b0;
    end else if (clear_req && (state_q != ST_CLEAR)) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      sweep_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      sweep_q  <= sweep_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  // Queue storage needs no reset: occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= host_addr;
      fifo_data_q[wr_ptr_q] <= host_data;
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign clear_busy = busy_q;
  assign fifo_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_palette_write_ctrl.sv
// tb_palette_write_ctrl: directed scenarios plus a randomized queue/commit phase
// checked against a queue-based reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_palette_write_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int NPAL  = 1 << AW;

  logic          clk;
  logic          rst;
  logic          host_valid;
  logic          host_ready;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          clear_req;
  logic          clear_busy;
  logic          vblank;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [$clog2(DEPTH):0] fifo_count;

  int n_cmp;
  int n_bad;
  int cyc;

  palette_write_ctrl #(
    .FIFO_DEPTH(DEPTH),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .host_valid(host_valid),
    .host_ready(host_ready),
    .host_addr (host_addr),
    .host_data (host_data),
    .clear_req (clear_req),
    .clear_busy(clear_busy),
    .vblank    (vblank),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; a request accepted on this edge is withdrawn.
  task automatic step();
    logic acc;
    acc = host_valid && host_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) host_valid = 1'b0;
  endtask

  task automatic push_entry(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_addr  = a;
    host_data  = d;
    host_valid = 1'b1;
    for (int i = 0; i < 50 && host_valid; i++) step();
    chk("push_accept", {31'd0, host_valid}, 32'd0);
  endtask

  task automatic wait_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int budget);
    int k;
    k = 0;
    step();
    while (!mem_we && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_seen"}, {31'd0, mem_we}, 32'd1);
    chk({tag, "_addr"}, {22'd0, mem_addr}, {22'd0, a});
    chk({tag, "_data"}, {16'd0, mem_wdata}, {16'd0, d});
  endtask

  // Expects the zero sweep to begin on the next clock; optional clear_req at sweep index clr_at.
  task automatic check_sweep(input string tag, input int clr_at);
    int bad;
    int extra;
    bad = 0;
    for (int k = 0; k < NPAL; k++) begin
      if (k == clr_at) clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      if (!(mem_we === 1'b1 && clear_busy === 1'b1 && mem_addr === AW'(k) && mem_wdata === '0))
        bad++;
    end
    chk({tag, "_sweep_errs"}, bad, 0);
    step();
    chk({tag, "_busy_end"}, {31'd0, clear_busy}, 32'd0);
    chk({tag, "_we_end"}, {31'd0, mem_we}, 32'd0);
    extra = 0;
    if (clr_at >= 0) begin
      for (int k = 0; k < 10; k++) begin
        step();
        if (mem_we !== 1'b0 || clear_busy !== 1'b0) extra++;
      end
      chk({tag, "_no_resweep"}, extra, 0);
    end
  endtask

  initial begin
    logic [AW+DW-1:0] mq[$];
    logic [AW+DW-1:0] ent;
    logic exp_ready;
    logic pushed;
    logic vb_edge;
    int   cnt;
    int   found;

    n_cmp = 0; n_bad = 0; cyc = 0;
    rst = 1'b1; host_valid = 1'b0; host_addr = '0; host_data = '0;
    clear_req = 1'b0; vblank = 1'b0;

    // Reset values
    step(); step();
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_busy", {31'd0, clear_busy}, 32'd0);
    chk("rst_ready", {31'd0, host_ready}, 32'd1);
    chk("rst_count", fifo_count, 32'd0);

    // No write on the first edge after release
    rst = 1'b0;
    host_addr = 10'h123; host_data = 16'hABCD; host_valid = 1'b1; vblank = 1'b1;
    step();
    chk("post_rst_edge1_we", {31'd0, mem_we}, 32'd0);
    wait_write("post_rst", 10'h123, 16'hABCD, 4);
    step();
    chk("post_rst_count", fifo_count, 32'd0);

    // Writes held outside vblank, then committed in order on consecutive cycles
    vblank = 1'b0;
    step();
    push_entry(10'h005, 16'h7C00);
    push_entry(10'h006, 16'h03E0);
    step();
    chk("hold_count", fifo_count, 32'd2);
    chk("hold_we", {31'd0, mem_we}, 32'd0);
    vblank = 1'b1;
    wait_write("vb_w0", 10'h005, 16'h7C00, 4);
    wait_write("vb_w1", 10'h006, 16'h03E0, 0);
    step();
    chk("vb_count", fifo_count, 32'd0);
    vblank = 1'b0;

    // Full queue back-pressure; fifth entry accepted once space frees
    for (int i = 0; i < DEPTH; i++) push_entry(AW'(10'h100 + i), DW'(16'h1000 + i));
    chk("full_count", fifo_count, DEPTH);
    chk("full_ready", {31'd0, host_ready}, 32'd0);
    host_addr = 10'h104; host_data = 16'h1004; host_valid = 1'b1;
    step(); step(); step();
    chk("fifth_held", {31'd0, host_valid}, 32'd1);
    vblank = 1'b1;
    wait_write("full_w0", 10'h100, 16'h1000, 4);
    wait_write("full_w1", 10'h101, 16'h1001, 0);
    wait_write("full_w2", 10'h102, 16'h1002, 0);
    wait_write("full_w3", 10'h103, 16'h1003, 0);
    wait_write("full_w4", 10'h104, 16'h1004, 0);
    chk("fifth_taken", {31'd0, host_valid}, 32'd0);
    step();
    chk("full_drained", fifo_count, 32'd0);
    vblank = 1'b0;

    // Clear sweep from idle, with a second request mid-sweep ignored
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    chk("clr_pend_busy", {31'd0, clear_busy}, 32'd0);
    check_sweep("clr_idle", 512);

    // Clear requested alongside the first pop of three; queue survives the sweep
    push_entry(10'h0A0, 16'hAAAA);
    push_entry(10'h0A1, 16'hBBBB);
    push_entry(10'h0A2, 16'hCCCC);
    vblank = 1'b1;
    step();
    chk("dc_enter_we", {31'd0, mem_we}, 32'd0);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    chk("dc_pop_we", {31'd0, mem_we}, 32'd1);
    chk("dc_pop_addr", {22'd0, mem_addr}, 32'h0A0);
    chk("dc_count", fifo_count, 32'd2);
    check_sweep("dc", -1);
    wait_write("dc_w1", 10'h0A1, 16'hBBBB, 4);
    wait_write("dc_w2", 10'h0A2, 16'hCCCC, 0);
    step();
    chk("dc_empty", fifo_count, 32'd0);
    vblank = 1'b0;

    // vblank falls after one pop; remaining entries wait for the next blanking
    push_entry(10'h0D0, 16'h0D0D);
    push_entry(10'h0E0, 16'h0E0E);
    push_entry(10'h0F0, 16'h0F0F);
    vblank = 1'b1;
    wait_write("vd_w0", 10'h0D0, 16'h0D0D, 4);
    vblank = 1'b0;
    step();
    chk("vd_stop_we", {31'd0, mem_we}, 32'd0);
    chk("vd_count", fifo_count, 32'd2);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin step(); if (mem_we !== 1'b0) cnt++; end
    chk("vd_idle_writes", cnt, 0);
    vblank = 1'b1;
    wait_write("vd_w1", 10'h0E0, 16'h0E0E, 4);
    wait_write("vd_w2", 10'h0F0, 16'h0F0F, 0);
    vblank = 1'b0;
    step();

    // Randomized pushes and vblank against the queue model
    mq.delete();
    for (int i = 0; i < 400 + 3 * DEPTH + 10; i++) begin
      if (i < 400) begin
        host_valid = ($urandom_range(0, 2) != 0);
        host_addr  = AW'($urandom);
        host_data  = DW'($urandom);
        if ($urandom_range(0, 7) == 0) vblank = ~vblank;
      end else begin
        host_valid = 1'b0;
        vblank     = 1'b1;
      end
      exp_ready = (mq.size() != DEPTH);
      chk("rnd_ready", {31'd0, host_ready}, {31'd0, exp_ready});
      pushed  = host_valid && exp_ready;
      ent     = {host_addr, host_data};
      vb_edge = vblank;
      step();
      if (pushed) mq.push_back(ent);
      if (mem_we === 1'b1) begin
        chk("rnd_vblank_at_pop", {31'd0, vb_edge}, 32'd1);
        chk("rnd_pop_nonempty", {31'd0, (mq.size() != 0)}, 32'd1);
        if (mq.size() != 0) begin
          ent = mq.pop_front();
          chk("rnd_addr", {22'd0, mem_addr}, {22'd0, ent[AW+DW-1:DW]});
          chk("rnd_data", {16'd0, mem_wdata}, {16'd0, ent[DW-1:0]});
        end
      end
      chk("rnd_count", fifo_count, mq.size());
    end
    chk("rnd_model_empty", mq.size(), 0);
    vblank = 1'b0;
    host_valid = 1'b0;
    step();

    // Reset mid-sweep discards queue and aborts the sweep
    push_entry(10'h3F0, 16'h1234);
    push_entry(10'h3F1, 16'h5678);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    found = 0;
    for (int i = 0; i < NPAL + 10 && found == 0; i++) begin
      step();
      if (mem_we === 1'b1 && mem_addr === 10'h200) found = 1;
    end
    chk("mid_rst_reach_200", found, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rst_addr", {22'd0, mem_addr}, 32'd0);
    chk("mid_rst_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("mid_rst_busy", {31'd0, clear_busy}, 32'd0);
    chk("mid_rst_count", fifo_count, 32'd0);
    chk("mid_rst_ready", {31'd0, host_ready}, 32'd1);
    step();
    rst = 1'b0;
    vblank = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); if (mem_we !== 1'b0 || clear_busy !== 1'b0) cnt++; end
    chk("post_abort_quiet", cnt, 0);
    chk("post_abort_count", fifo_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/palette_write_ctrl.md
PALETTE_WRITE_CTRL -- requirements
Module: palette_write_ctrl

Interface
REQ-001 The parameter list SHALL be: FIFO_DEPTH, 4, host write-queue depth (power of two, 2..16).
REQ-002 The parameter list SHALL be: ADDR_W, 10, palette address width (1024 entries).
REQ-003 The parameter list SHALL be: DATA_W, 16, palette entry width.
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous and active-high.
REQ-006 Port: host_valid  input  1  host write request.
REQ-007 Port: host_ready  output  1  queue can accept an entry.
REQ-008 Port: host_addr  input  ADDR_W  palette index to write.
REQ-009 Port: host_data  input  DATA_W  palette colour to write.
REQ-010 Port: clear_req  input  1  single-cycle request to zero the whole palette.
REQ-011 Port: clear_busy  output  1  clear sweep in progress.
REQ-012 Port: vblank  input  1  high while the display is in vertical blanking; host writes commit only then.
REQ-013 Port: mem_we  output  1  palette memory write enable (drives port-1 write of the palette memory).
REQ-014 Port: mem_addr  output  ADDR_W  palette memory port-1 address.
REQ-015 Port: mem_wdata  output  DATA_W  palette memory write data.
REQ-016 Port: fifo_count  output  clog2(FIFO_DEPTH)+1  entries currently queued.

Function
REQ-017 A push SHALL occur on a rising edge with host_valid=1 and host_ready=1; host_ready SHALL equal (fifo_count != FIFO_DEPTH), combinational from registered count only.
REQ-018 The queue SHALL be FIFO-ordered, with wrap-around read/write pointers modulo FIFO_DEPTH.
REQ-019 States SHALL be IDLE, DRAIN, CLEAR.
REQ-020 IDLE -> CLEAR when clear is pending (priority); else IDLE -> DRAIN when vblank=1 and fifo_count>0; else stay.
REQ-021 DRAIN: pop one entry per cycle while vblank=1 and queue non-empty; DRAIN -> CLEAR if clear pending; DRAIN -> IDLE when the queue is empty or vblank=0 (no pop that cycle).
REQ-022 A pop SHALL register {mem_we=1, mem_addr=entry addr, mem_wdata=entry data} on the same edge, giving one-cycle latency pop-to-memory-write; mem_we=0 in every other cycle.
REQ-023 CLEAR: issue writes of 0 to addresses 0,1,...,2**ADDR_W-1, one per cycle regardless of vblank, then -> IDLE; sweep takes exactly 2**ADDR_W cycles of mem_we=1.
REQ-024 clear_req SHALL set a pending flag; clear_req during CLEAR SHALL be ignored (not re-queued); pending flag clears on entry to CLEAR.
REQ-025 clear_busy SHALL be 1 from the edge entering CLEAR through the cycle of the last sweep write.
REQ-026 Queued entries SHALL NOT be discarded by a clear; pushes remain accepted during CLEAR and commit afterwards (they overwrite zeros).
REQ-027 Simultaneous push and pop SHALL leave fifo_count unchanged; push when full SHALL be impossible (ready=0); pop when empty SHALL never occur.
REQ-028 The sweep address counter SHALL be ADDR_W+1 bits wide to detect terminal count without wrapping to 0.

Reset
REQ-029 While rst=1: state=IDLE, pointers and fifo_count=0, pending flag=0, sweep counter=0, mem_we=0, mem_addr=0, mem_wdata=0, clear_busy=0, host_ready=1.
REQ-030 Reset asserted mid-CLEAR or mid-DRAIN SHALL abort immediately and discard queue contents; no partial write is issued after release.
REQ-031 After release, the first mem_we SHALL occur no earlier than the second rising edge.

Verification
REQ-032 vblank=0, push (0x005,0x7C00),(0x006,0x03E0) -> fifo_count=2, mem_we stays 0; raise vblank -> writes to 0x005 then 0x006 on consecutive cycles, fifo_count returns 0.
REQ-033 vblank=0, push 5 entries with FIFO_DEPTH=4 -> host_ready=0 after 4th, 5th held; vblank=1 -> entries drain in order, 5th accepted when ready returns 1.
REQ-034 clear_req pulse in IDLE -> clear_busy=1 for 1024 cycles, mem_addr 0x000..0x3FF with mem_wdata=0, then IDLE; second clear_req mid-sweep -> no second sweep.
REQ-035 3 entries queued, vblank=1, clear_req during DRAIN after first pop -> sweep 1024 writes, then remaining 2 entries written.
REQ-036 vblank drops after 1 of 3 pops -> DRAIN->IDLE, fifo_count=2; vblank rises -> remaining 2 written.
REQ-037 rst pulsed at sweep address 0x200 -> all outputs 0, fifo_count=0, no further mem_we until new request.
